// File: rtl/fifo_rd_burst_master.sv
// rtl/fifo_rd_burst_master.sv - read-side burst master pulling len words from the async FIFO onto a valid/ready stream
module fifo_rd_burst_master #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             fifo_rd_en_o,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  input  logic             fifo_empty_i,
  input  logic             fifo_rd_error_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic             m_last_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [CNT_W-1:0] req_cnt;   // reads still to be issued (grows by one on each retry)
  logic [CNT_W-1:0] out_cnt;   // words still to be handed downstream
  logic [CNT_W-1:0] req_nxt;

  // Three-entry circular buffer: covers one word in flight plus downstream stalls
  logic [WIDTH-1:0] buf_mem [0:2];
  logic [1:0]       rd_ptr;
  logic [1:0]       wr_ptr;
  logic [1:0]       occ;
  logic             inflight;  // a read was issued last cycle; its data is on the bus now
  logic [2:0]       pending;

  logic push;
  logic pop;
  logic retry;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    ptr_inc = (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Slots already claimed: stored words plus the one returning this cycle.
  // Pops are deliberately not credited so m_ready_i never reaches fifo_rd_en_o.
  assign pending      = {1'b0, occ} + {2'b00, inflight};
  assign fifo_rd_en_o = (state == S_RUN) && !fifo_empty_i && (req_cnt != '0) && (pending < 3'd3);

  assign push  = inflight && !fifo_rd_error_i;
  assign retry = inflight && fifo_rd_error_i;

  assign m_valid_o = (occ != 2'd0);
  assign m_data_o  = buf_mem[rd_ptr];
  assign m_last_o  = m_valid_o && (out_cnt == CNT_ONE);
  assign pop       = m_valid_o && m_ready_i;

  // Next read count: one fewer per issued read, one more per discarded (errored) return
  always_comb begin
    req_nxt = req_cnt;
    if (fifo_rd_en_o) begin
      req_nxt = req_nxt - CNT_ONE;
    end
    if (retry) begin
      req_nxt = req_nxt + CNT_ONE;
    end
  end

  // Burst control FSM with registered status outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= S_IDLE;
      req_cnt <= '0;
      out_cnt <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            err_o <= 1'b0;
            if (len_i != '0) begin
              state   <= S_RUN;
              req_cnt <= len_i;
              out_cnt <= len_i;
              busy_o  <= 1'b1;
            end else begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end
          end
        end
        S_RUN: begin
          req_cnt <= req_nxt;
          if (pop && (out_cnt != '0)) begin
            out_cnt <= out_cnt - CNT_ONE;
          end
          if (retry) begin
            err_o <= 1'b1;
          end
          if (req_nxt == '0) begin
            state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          req_cnt <= req_nxt;
          if (pop && (out_cnt != '0)) begin
            out_cnt <= out_cnt - CNT_ONE;
          end
          if (retry) begin
            // A late error means one more word must still be fetched
            err_o <= 1'b1;
            state <= S_RUN;
          end else if ((out_cnt == '0) && !inflight) begin
            state  <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output buffer and read-latency tracking
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
      occ      <= 2'd0;
      inflight <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        buf_mem[i] <= '0;
      end
    end else begin
      inflight <= fifo_rd_en_o;
      if (push) begin
        buf_mem[wr_ptr] <= fifo_rdata_i;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_burst_master.sv
// tb/tb_fifo_rd_burst_master.sv - directed self-checking bench for fifo_rd_burst_master
module tb_fifo_rd_burst_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = 8'd0;
  logic       m_ready = 1'b0;
  logic [3:0] fifo_rdata = 4'd0;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_error = 1'b0;

  logic       busy;
  logic       done;
  logic       err;
  logic       rd_en;
  logic [3:0] m_data;
  logic       m_valid;
  logic       m_last;

  int checks = 0;
  int errors = 0;

  // FIFO model state
  logic [3:0] fq[$];
  int         rd_num = 0;
  int         err_target = -1;
  logic       rd_en_s = 1'b0;
  int         cyc = 0;

  // Monitor records
  int         rd_count = 0;
  int         done_count = 0;
  int         rd_cyc[$];
  logic [3:0] rx_data[$];
  logic       rx_last[$];
  int         rx_cyc[$];

  fifo_rd_burst_master #(.WIDTH(4), .CNT_W(8)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .start_i         (start),
    .len_i           (len),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err),
    .fifo_rd_en_o    (rd_en),
    .fifo_rdata_i    (fifo_rdata),
    .fifo_empty_i    (fifo_empty),
    .fifo_rd_error_i (fifo_rd_error),
    .m_data_o        (m_data),
    .m_valid_o       (m_valid),
    .m_ready_i       (m_ready),
    .m_last_o        (m_last)
  );

  always #5 clk = ~clk;

  // FIFO read port: data and error appear the cycle after a sampled read enable
  always @(posedge clk) begin
    cyc <= cyc + 1;
    fifo_rd_error <= 1'b0;
    if (rd_en_s) begin
      rd_num = rd_num + 1;
      if (rd_num == err_target) begin
        fifo_rd_error <= 1'b1;
      end else if (fq.size() > 0) begin
        fifo_rdata <= fq.pop_front();
      end
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Mid-cycle observation of the DUT
  always @(negedge clk) begin
    rd_en_s = rd_en;
    if (rd_en) begin
      rd_count = rd_count + 1;
      rd_cyc.push_back(cyc);
    end
    if (m_valid && m_ready) begin
      rx_data.push_back(m_data);
      rx_last.push_back(m_last);
      rx_cyc.push_back(cyc);
    end
    if (done) begin
      done_count = done_count + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done_count != base) break;
    end
    tick();
    tick();
  endtask

  task automatic pulse_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = 8'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({busy, done, err, rd_en, m_valid, m_last, m_data} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {busy, done, err, rd_en, m_valid, m_last, m_data});
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b rd_en=%b want 0 0", busy, rd_en);
    end
  endtask

  task automatic test_basic();
    int rb, rxb, db, s_cyc;
    for (int i = 1; i <= 5; i++) fq.push_back(4'(i));
    m_ready = 1'b1;
    tick();
    rb = rd_count; rxb = rx_data.size(); db = done_count;
    pulse_start(8'd5);
    s_cyc = cyc;
    wait_done(db);
    checks++;
    if (rx_data.size() - rxb !== 5) begin
      errors++;
      $display("FAIL basic_count got %0d want 5", rx_data.size() - rxb);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rx_data[rxb+i] !== 4'(i + 1) || rx_last[rxb+i] !== (i == 4) || rx_cyc[rxb+i] !== s_cyc + 2 + i) begin
          errors++;
          $display("FAIL basic_word%0d got d=%0d l=%b c=%0d want d=%0d l=%b c=%0d", i,
                   rx_data[rxb+i], rx_last[rxb+i], rx_cyc[rxb+i], i + 1, (i == 4), s_cyc + 2 + i);
        end
      end
    end
    checks++;
    if (rd_count - rb !== 5 || rd_cyc[rb] !== s_cyc) begin
      errors++;
      $display("FAIL basic_reads got n=%0d first=%0d want n=5 first=%0d", rd_count - rb, rd_cyc[rb], s_cyc);
    end
    checks++;
    if (done_count - db !== 1 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got done=%0d busy=%b err=%b want 1 0 0", done_count - db, busy, err);
    end
  endtask

  task automatic test_stall();
    int rb, rxb, db;
    bit stable_ok;
    logic [3:0] exp_w [0:3];
    exp_w[0] = 4'd9; exp_w[1] = 4'd10; exp_w[2] = 4'd11; exp_w[3] = 4'd12;
    for (int i = 9; i <= 16; i++) fq.push_back(4'(i));
    m_ready = 1'b0;
    tick();
    rb = rd_count; rxb = rx_data.size(); db = done_count;
    pulse_start(8'd4);
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_valid && (m_data !== 4'd9 || m_last !== 1'b0)) stable_ok = 1'b0;
    end
    checks++;
    if (!stable_ok || m_valid !== 1'b1 || m_data !== 4'd9) begin
      errors++;
      $display("FAIL stall_hold got v=%b d=%0d stable=%b want v=1 d=9 stable=1", m_valid, m_data, stable_ok);
    end
    checks++;
    if (rd_count - rb !== 3 || rd_en !== 1'b0) begin
      errors++;
      $display("FAIL stall_reads got n=%0d rd_en=%b want 3 0", rd_count - rb, rd_en);
    end
    m_ready = 1'b1;
    wait_done(db);
    checks++;
    if (rx_data.size() - rxb !== 4) begin
      errors++;
      $display("FAIL stall_count got %0d want 4", rx_data.size() - rxb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rx_data[rxb+i] !== exp_w[i] || rx_last[rxb+i] !== (i == 3)) begin
          errors++;
          $display("FAIL stall_word%0d got d=%0d l=%b want d=%0d l=%b", i, rx_data[rxb+i], rx_last[rxb+i], exp_w[i], (i == 3));
        end
      end
    end
    checks++;
    if (fq.size() !== 4 || rd_count - rb !== 4 || done_count - db !== 1) begin
      errors++;
      $display("FAIL stall_tail got left=%0d reads=%0d done=%0d want 4 4 1", fq.size(), rd_count - rb, done_count - db);
    end
    fq.delete();
    tick();
  endtask

  task automatic test_empty_start();
    int rb, rxb, db;
    bit busy_ok;
    m_ready = 1'b1;
    tick();
    rb = rd_count; rxb = rx_data.size(); db = done_count;
    pulse_start(8'd3);
    busy_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
    end
    checks++;
    if (!busy_ok || rd_count - rb !== 0) begin
      errors++;
      $display("FAIL empty_wait got busy_ok=%b reads=%0d want 1 0", busy_ok, rd_count - rb);
    end
    fq.push_back(4'd5); fq.push_back(4'd6); fq.push_back(4'd7);
    wait_done(db);
    checks++;
    if (rx_data.size() - rxb !== 3 || rx_data[rxb] !== 4'd5 || rx_data[rxb+1] !== 4'd6 || rx_data[rxb+2] !== 4'd7) begin
      errors++;
      $display("FAIL empty_words got n=%0d want 3 words 5 6 7", rx_data.size() - rxb);
    end
    checks++;
    if (done_count - db !== 1 || busy !== 1'b0 || rd_count - rb !== 3) begin
      errors++;
      $display("FAIL empty_done got done=%0d busy=%b reads=%0d want 1 0 3", done_count - db, busy, rd_count - rb);
    end
  endtask

  task automatic test_zero_len();
    int rb, rxb;
    tick();
    rb = rd_count; rxb = rx_data.size();
    pulse_start(8'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done got done=%b busy=%b want 1 0", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse got done=%b want 0", done);
    end
    tick();
    tick();
    checks++;
    if (rd_count - rb !== 0 || rx_data.size() - rxb !== 0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL zero_quiet got reads=%0d words=%0d v=%b want 0 0 0", rd_count - rb, rx_data.size() - rxb, m_valid);
    end
  endtask

  task automatic test_rd_error();
    int rb, rxb, db;
    fq.push_back(4'd3); fq.push_back(4'd4); fq.push_back(4'd5);
    m_ready = 1'b1;
    tick();
    rb = rd_count; rxb = rx_data.size(); db = done_count;
    err_target = rd_num + 2;
    pulse_start(8'd3);
    wait_done(db);
    tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got %b want 1", err);
    end
    checks++;
    if (rd_count - rb !== 4 || rx_data.size() - rxb !== 3) begin
      errors++;
      $display("FAIL err_counts got reads=%0d words=%0d want 4 3", rd_count - rb, rx_data.size() - rxb);
    end else begin
      checks++;
      if (rx_data[rxb] !== 4'd3 || rx_data[rxb+1] !== 4'd4 || rx_data[rxb+2] !== 4'd5 || rx_last[rxb+2] !== 1'b1) begin
        errors++;
        $display("FAIL err_words got %0d %0d %0d last=%b want 3 4 5 last=1",
                 rx_data[rxb], rx_data[rxb+1], rx_data[rxb+2], rx_last[rxb+2]);
      end
    end
    err_target = -1;
    pulse_start(8'd0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b want 0", err);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int rxb;
    bit quiet_ok;
    for (int i = 1; i <= 5; i++) fq.push_back(4'(i + 8));
    m_ready = 1'b0;
    tick();
    pulse_start(8'd5);
    tick(); tick(); tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 4'd9) begin
      errors++;
      $display("FAIL mid_pre got v=%b d=%0d want 1 9", m_valid, m_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, rd_en, m_valid, m_last, m_data} !== 10'd0) begin
      errors++;
      $display("FAIL mid_async got %b want 0", {busy, done, err, rd_en, m_valid, m_last, m_data});
    end
    rst_n = 1'b1;
    m_ready = 1'b1;
    rxb = rx_data.size();
    quiet_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m_valid !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) quiet_ok = 1'b0;
    end
    checks++;
    if (!quiet_ok || rx_data.size() - rxb !== 0) begin
      errors++;
      $display("FAIL mid_stale got quiet=%b words=%0d want 1 0", quiet_ok, rx_data.size() - rxb);
    end
    fq.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_empty_start();
    test_zero_len();
    test_rd_error();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
